// File: rtl/evm_pkg.sv
// Shared state encoding and default sizing for the electronic voting machine.
package evm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    HOLD   = 2'd2,
    CLOSED = 2'd3
  } state_e;

  localparam int NUM_PARTIES_DEF = 4;
  localparam int CNT_W_DEF       = 8;
  localparam int TOTAL_W_DEF     = 10;

endpackage

// File: rtl/evm_btn_edge.sv
// Cast-button rising-edge detector. After reset the button must be seen low
// once before any edge is reported, so a button held through reset casts nothing.
module evm_btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic btn_q;
  logic armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      btn_q <= btn;
      if (!btn) armed_q <= 1'b1;
    end
  end

  assign rise = btn & ~btn_q & armed_q;

endmodule

// File: rtl/evm_param.sv
// Parameterised voting machine: session FSM, saturating per-party tallies,
// registered count readout. Define EVM_WINNER_EN to add the winner/tie outputs.
module evm_param
  import evm_pkg::*;
#(
  parameter int NUM_PARTIES = NUM_PARTIES_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TOTAL_W     = TOTAL_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_vote,
  input  logic                           close_vote,
  input  logic                           btn,
  input  logic [NUM_PARTIES-1:0]         vote_input,
  input  logic [$clog2(NUM_PARTIES)-1:0] rd_sel,
  output logic [NUM_PARTIES-1:0]         party_led,
  output logic                           vote_accepted,
  output logic                           invalid_vote,
  output logic [TOTAL_W-1:0]             total_votes,
  output logic [CNT_W-1:0]               rd_count,
  output logic                           closed
`ifdef EVM_WINNER_EN
  ,
  output logic [NUM_PARTIES-1:0]         winner,
  output logic                           tie
`endif
);

  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [TOTAL_W-1:0] TOTAL_MAX = '1;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q [NUM_PARTIES];
  logic [TOTAL_W-1:0]       total_q;
  logic [NUM_PARTIES-1:0]   led_q;
  logic                     acc_q, acc_d;
  logic                     inv_q, inv_d;
  logic [CNT_W-1:0]         rd_q, rd_d;
  logic                     rise;
  logic                     target_full;
  logic                     vote_ok;

  evm_btn_edge u_btn_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn),
    .rise (rise)
  );

  always_comb begin
    target_full = 1'b0;
    for (int i = 0; i < NUM_PARTIES; i++)
      if (vote_input[i] && cnt_q[i] == CNT_MAX) target_full = 1'b1;
  end

  assign vote_ok = ($countones(vote_input) == 1) && !target_full && (total_q != TOTAL_MAX);

  // Close has priority over everything, including a cast in the same cycle.
  always_comb begin
    state_d = state_q;
    acc_d   = 1'b0;
    inv_d   = 1'b0;
    case (state_q)
      IDLE:   if (start_vote) state_d = OPEN;
      OPEN: begin
        if (!start_vote) state_d = IDLE;
        else if (rise) begin
          state_d = HOLD;
          acc_d   = vote_ok;
          inv_d   = !vote_ok;
        end
      end
      HOLD: begin
        if (!start_vote) state_d = IDLE;
        else if (!btn)   state_d = OPEN;
      end
      CLOSED:  state_d = CLOSED;
      default: state_d = IDLE;
    endcase
    if (close_vote && state_q != CLOSED) begin
      state_d = CLOSED;
      acc_d   = 1'b0;
      inv_d   = 1'b0;
    end
  end

  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NUM_PARTIES; i++)
      if (int'(rd_sel) == i) rd_d = cnt_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      total_q <= '0;
      led_q   <= '0;
      acc_q   <= 1'b0;
      inv_q   <= 1'b0;
      rd_q    <= '0;
      for (int i = 0; i < NUM_PARTIES; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      inv_q   <= inv_d;
      rd_q    <= rd_d;
      if (acc_d) begin
        total_q <= total_q + 1'b1;
        led_q   <= vote_input;
      end
      for (int i = 0; i < NUM_PARTIES; i++)
        if (acc_d && vote_input[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
    end
  end

  assign party_led     = led_q;
  assign vote_accepted = acc_q;
  assign invalid_vote  = inv_q;
  assign total_votes   = total_q;
  assign rd_count      = rd_q;
  assign closed        = (state_q == CLOSED);

`ifdef EVM_WINNER_EN
  logic [CNT_W-1:0]       best;
  logic [NUM_PARTIES-1:0] win_d, win_q;
  logic                   tie_d, tie_q;
  logic                   found;

  // Lowest index among the maximum tallies wins; any further match flags a tie.
  always_comb begin
    best  = '0;
    win_d = '0;
    tie_d = 1'b0;
    found = 1'b0;
    for (int i = 0; i < NUM_PARTIES; i++)
      if (cnt_q[i] > best) best = cnt_q[i];
    for (int i = 0; i < NUM_PARTIES; i++) begin
      if (cnt_q[i] == best) begin
        if (found) tie_d = 1'b1;
        else       win_d[i] = 1'b1;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
      tie_q <= 1'b0;
    end else if (state_q == CLOSED) begin
      win_q <= win_d;
      tie_q <= tie_d;
    end else begin
      win_q <= '0;
      tie_q <= 1'b0;
    end
  end

  assign winner = win_q;
  assign tie    = tie_q;
`endif

endmodule

// File: tb/tb_evm_param.sv
// Bench for evm_param with narrow counters so saturation is reachable;
// winner/tie are exercised when EVM_WINNER_EN is defined.
module tb_evm_param;

  localparam int NP   = 4;
  localparam int CW   = 2;
  localparam int TW   = 3;
  localparam int CMAX = (1 << CW) - 1;
  localparam int TMAX = (1 << TW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start_vote, close_vote, btn;
  logic [NP-1:0]   vote_input;
  logic [1:0]      rd_sel;
  logic [NP-1:0]   party_led;
  logic            vote_accepted, invalid_vote;
  logic [TW-1:0]   total_votes;
  logic [CW-1:0]   rd_count;
  logic            closed;
`ifdef EVM_WINNER_EN
  logic [NP-1:0]   winner;
  logic            tie;
`endif

  evm_param #(.NUM_PARTIES(NP), .CNT_W(CW), .TOTAL_W(TW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_vote   (start_vote),
    .close_vote   (close_vote),
    .btn          (btn),
    .vote_input   (vote_input),
    .rd_sel       (rd_sel),
    .party_led    (party_led),
    .vote_accepted(vote_accepted),
    .invalid_vote (invalid_vote),
    .total_votes  (total_votes),
    .rd_count     (rd_count),
    .closed       (closed)
`ifdef EVM_WINNER_EN
    ,
    .winner       (winner),
    .tie          (tie)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain tallies plus session/close flags.
  int            m_cnt [NP];
  int            m_total;
  logic [NP-1:0] m_led;
  bit            m_sess, m_closed, m_armed, m_prev_btn;
  bit            e_acc, e_inv, e_tie;
  int            e_rd;
  logic [NP-1:0] e_win;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("vote_accepted", 32'(vote_accepted), 32'(e_acc));
    chk("invalid_vote",  32'(invalid_vote),  32'(e_inv));
    chk("total_votes",   32'(total_votes),   m_total);
    chk("party_led",     32'(party_led),     32'(m_led));
    chk("closed",        32'(closed),        32'(m_closed));
    chk("rd_count",      32'(rd_count),      e_rd);
`ifdef EVM_WINNER_EN
    chk("winner",        32'(winner),        32'(e_win));
    chk("tie",           32'(tie),           32'(e_tie));
`endif
  endtask

  task automatic model_winner();
    int best, hits;
    best = 0; hits = 0; e_win = '0;
    for (int i = 0; i < NP; i++) if (m_cnt[i] > best) best = m_cnt[i];
    for (int i = 0; i < NP; i++) if (m_cnt[i] == best) begin
      if (hits == 0) e_win[i] = 1'b1;
      hits++;
    end
    e_tie = (hits > 1);
  endtask

  task automatic tick();
    bit rise, was_closed;
    int idx;
    rise = btn && !m_prev_btn && m_armed;
    if (!btn) m_armed = 1;
    m_prev_btn = btn;
    was_closed = m_closed;
    e_rd = (int'(rd_sel) < NP) ? m_cnt[rd_sel] : 0;
    if (was_closed) model_winner();
    else begin e_win = '0; e_tie = 0; end
    e_acc = 0; e_inv = 0;
    if (m_closed) begin end
    else if (close_vote) begin m_closed = 1; m_sess = 0; end
    else if (!m_sess) m_sess = start_vote;
    else if (!start_vote) m_sess = 0;
    else if (rise) begin
      idx = -1;
      for (int i = 0; i < NP; i++) if (vote_input[i]) idx = i;
      if ($countones(vote_input) == 1 && m_cnt[idx] < CMAX && m_total < TMAX) begin
        m_cnt[idx]++; m_total++; m_led = vote_input; e_acc = 1;
      end else e_inv = 1;
    end
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NP; i++) m_cnt[i] = 0;
    m_total = 0; m_led = '0; m_sess = 0; m_closed = 0; m_armed = 0; m_prev_btn = 0;
    e_acc = 0; e_inv = 0; e_rd = 0; e_win = '0; e_tie = 0;
    check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic cast(input logic [NP-1:0] v);
    btn = 1'b1; vote_input = v; tick();
    btn = 1'b0; tick();
  endtask

  initial begin
    rst_n = 1'b1; start_vote = 0; close_vote = 0; btn = 0; vote_input = '0; rd_sel = '0;
    do_reset();
    tick();
    start_vote = 1'b1;
    tick();

    cast(4'b0001);
    chk("single_vote_led", 32'(party_led), 32'h1);
    chk("single_vote_total", 32'(total_votes), 32'd1);
    cast(4'b0101);
    cast(4'b0000);

    btn = 1'b1; vote_input = 4'b0010;
    for (int k = 0; k < 5; k++) tick();
    btn = 1'b0; tick();

    for (int k = 0; k < 4; k++) cast(4'b0100);
    rd_sel = 2'd2; tick(); tick();
    chk("sat_count_p2", 32'(rd_count), 32'd3);
    chk("sat_total", 32'(total_votes), 32'd5);

    for (int c = 0; c < 250; c++) begin
      btn        = ($urandom_range(0, 2) == 0);
      vote_input = ($urandom_range(0, 3) == 0) ? NP'($urandom) : NP'(1 << $urandom_range(0, NP - 1));
      start_vote = ($urandom_range(0, 19) != 0);
      rd_sel     = 2'($urandom);
      tick();
    end
    chk("total_saturated", 32'(total_votes), TMAX);

    start_vote = 1'b1; btn = 1'b0; tick(); tick();
    btn = 1'b1; vote_input = 4'b0001; tick();
    do_reset();
    for (int k = 0; k < 3; k++) tick();
    chk("held_btn_after_reset", 32'(total_votes), 32'd0);
    btn = 1'b0; tick();

    cast(4'b0001); cast(4'b0001); cast(4'b0010); cast(4'b0010); cast(4'b0100);
    chk("tally_total", 32'(total_votes), 32'd5);

    btn = 1'b1; vote_input = 4'b0001; close_vote = 1'b1; tick();
    chk("close_wins", 32'(closed), 32'd1);
    chk("close_no_pulse", 32'(vote_accepted), 32'd0);
    btn = 1'b0; tick();
`ifdef EVM_WINNER_EN
    chk("winner_tie_lowest", 32'(winner), 32'h1);
    chk("tie_flag", 32'(tie), 32'd1);
`endif
    close_vote = 1'b0;
    cast(4'b1000); cast(4'b0010);
    chk("closed_ignores_votes", 32'(total_votes), 32'd5);

    do_reset();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
